instruction_fetch_unit: RTL and testbench

// Sequencer for the asynchronous-read instruction ROM. Owns the program counter, drives the ROM

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_if.sv | 12 +
 rtl/instruction_fetch_unit_fetch_buffer.sv | 58 +++++
 rtl/instruction_fetch_unit.sv | 85 ++++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned INSTRUCTION_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0]              pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] address);
    return address[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode valid/ready channel carrying {pc, instruction}.
interface instruction_fetch_unit_if;

  logic                                                 out_valid;
  logic                                                 out_ready;
  logic [instruction_fetch_unit_pkg::XLEN-1:0]              out_pc;
  logic [instruction_fetch_unit_pkg::INSTRUCTION_WIDTH-1:0] out_instruction;

  modport master (output out_valid, output out_pc, output out_instruction, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instruction, output out_ready);

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO of fetch entries; flush dominates push and pop.
module instruction_fetch_unit_fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter sequencer for the async-read instruction ROM, feeding decode through a fetch buffer.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS  = 1024,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FIFO_DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         halt,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [XLEN-1:0]              rom_address,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_instruction,
  instruction_fetch_unit_if.master     out_bus,
  output logic                         fault,
  output logic [XLEN-1:0]              fault_pc
);

  localparam logic [XLEN:0] PC_LIMIT =
    (XLEN+1)'(longint'(DEPTH_WORDS) * longint'(INSTRUCTION_BYTES));

  logic [XLEN-1:0]               pc;
  logic                          range_err;
  logic                          pop;
  logic                          flush;
  logic                          fetch_en;
  fetch_entry_t                  wr_entry;
  fetch_entry_t                  head;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          full;
  logic                          empty;

  assign rom_address = pc;
  assign range_err   = ({1'b0, pc} >= PC_LIMIT);
  assign pop         = out_bus.out_valid && out_bus.out_ready;
  // Redirects are dropped entirely once faulted, so the flush is gated by fault too.
  assign flush       = redirect_valid && !fault;
  assign fetch_en    = !halt && !fault && !redirect_valid && !range_err && (!full || pop);
  assign wr_entry    = '{pc: pc, instruction: rom_instruction};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VECTOR;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (flush) begin
      if (is_misaligned(redirect_pc)) begin
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        pc <= redirect_pc;
      end
    end else if (range_err && !fault) begin
      fault    <= 1'b1;
      fault_pc <= pc;
    end else if (fetch_en) begin
      pc <= pc + XLEN'(INSTRUCTION_BYTES);
    end
  end

  instruction_fetch_unit_fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fetch_en),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign out_bus.out_valid       = !empty;
  assign out_bus.out_pc          = head.pc;
  assign out_bus.out_instruction = head.instruction;

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    32'(count) <= FIFO_DEPTH);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: a default-depth unit and a 4-word-ROM unit, each with a behavioural ROM.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        halt, halt2;
  logic        redirect_valid, redirect_valid2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic [31:0] rom_address, rom_address2;
  logic [31:0] rom_instruction, rom_instruction2;
  logic        fault, fault2;
  logic [31:0] fault_pc, fault_pc2;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit_if bus1 ();
  instruction_fetch_unit_if bus2 ();

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .out_bus         (bus1.master),
    .fault           (fault),
    .fault_pc        (fault_pc)
  );

  instruction_fetch_unit #(
    .DEPTH_WORDS (4)
  ) dut_small (
    .clk             (clk),
    .rst_n           (rst2_n),
    .halt            (halt2),
    .redirect_valid  (redirect_valid2),
    .redirect_pc     (redirect_pc2),
    .rom_address     (rom_address2),
    .rom_instruction (rom_instruction2),
    .out_bus         (bus2.master),
    .fault           (fault2),
    .fault_pc        (fault_pc2)
  );

  assign rom_instruction  = 32'h1000_0000 + (rom_address  >> 2);
  assign rom_instruction2 = 32'h1000_0000 + (rom_address2 >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    halt = 1'b0; halt2 = 1'b0;
    redirect_valid = 1'b0; redirect_valid2 = 1'b0;
    redirect_pc = '0; redirect_pc2 = '0;
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;

    // 1: reset state, then streaming one entry per cycle
    tick(); tick();
    check("rst_valid",    32'(bus1.out_valid), 32'd0);
    check("rst_fault",    32'(fault),          32'd0);
    check("rst_fault_pc", fault_pc,            32'd0);
    check("rst_rom_addr", rom_address,         32'd0);
    rst_n = 1'b1;
    check("pre_edge_valid", 32'(bus1.out_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stream_valid", 32'(bus1.out_valid), 32'd1);
      check("stream_pc",    bus1.out_pc,          32'(4 * k));
      check("stream_instr", bus1.out_instruction, 32'h1000_0000 + 32'(k));
      check("stream_addr",  rom_address,          32'(4 * (k + 1)));
    end

    // 2: backpressure fills buffer, pc stalls, then drains in order
    bus1.out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("bp_valid", 32'(bus1.out_valid), 32'd1);
    check("bp_head",  bus1.out_pc,         32'd0);
    check("bp_addr",  rom_address,         32'h8);
    bus1.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("bp_drain_pc", bus1.out_pc, 32'(4 * k));
      check("bp_drain_valid", 32'(bus1.out_valid), 32'd1);
    end

    // 3: redirect discards buffered entries
    bus1.out_ready = 1'b0;
    do_reset();
    tick(); tick();
    check("rd_pre_head", bus1.out_pc, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(bus1.out_valid), 32'd0);
    check("rd_addr",        rom_address,         32'h40);
    bus1.out_ready = 1'b1;
    tick();
    check("rd_first_valid", 32'(bus1.out_valid),  32'd1);
    check("rd_first_pc",    bus1.out_pc,          32'h40);
    check("rd_first_instr", bus1.out_instruction, 32'h1000_0010);
    tick();
    check("rd_second_pc",   bus1.out_pc,          32'h44);

    // 4: misaligned redirect faults, sticky until reset
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("mis_fault",    32'(fault),          32'd1);
    check("mis_fault_pc", fault_pc,            32'h42);
    check("mis_valid",    32'(bus1.out_valid), 32'd0);
    tick(); tick();
    check("mis_valid_later", 32'(bus1.out_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("mis_ignored_fault",    32'(fault),          32'd1);
    check("mis_ignored_fault_pc", fault_pc,            32'h42);
    check("mis_ignored_valid",    32'(bus1.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mis_rst_fault",    32'(fault), 32'd0);
    check("mis_rst_fault_pc", fault_pc,   32'd0);
    rst_n = 1'b1;
    tick();
    check("mis_restart_valid", 32'(bus1.out_valid), 32'd1);
    check("mis_restart_pc",    bus1.out_pc,          32'd0);

    // 5: small ROM runs off its end
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rng_pc",    bus2.out_pc,      32'(4 * k));
      check("rng_fault", 32'(fault2),      32'd0);
    end
    tick();
    check("rng_fault_set", 32'(fault2),          32'd1);
    check("rng_fault_pc",  fault_pc2,            32'h10);
    check("rng_valid",     32'(bus2.out_valid),  32'd0);

    // 6: halt drains, freezes pc, resumes; redirect beats halt; async reset mid-stream
    bus1.out_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    check("halt_pre_pc", bus1.out_pc, 32'h8);
    halt = 1'b1;
    tick();
    check("halt_drained", 32'(bus1.out_valid), 32'd0);
    check("halt_addr",    rom_address,         32'hC);
    tick();
    check("halt_addr_held", rom_address, 32'hC);
    halt = 1'b0;
    tick();
    check("halt_resume_valid", 32'(bus1.out_valid), 32'd1);
    check("halt_resume_pc",    bus1.out_pc,          32'hC);
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("halt_rd_addr",  rom_address,         32'h80);
    check("halt_rd_valid", 32'(bus1.out_valid), 32'd0);
    halt = 1'b0;
    tick();
    check("halt_rd_pc", bus1.out_pc, 32'h80);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus1.out_valid), 32'd0);
    check("async_rst_addr",  rom_address,         32'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
